// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and width helper for the round-robin arbiter
package arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker, first set bit at or above ptr with wrap
module rr_pick import arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ID_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] cand,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] oh,
  output logic [ID_W-1:0]  idx,
  output logic             any
);
  assign any = |cand;
  assign oh = any ? N_REQ'(1) << idx : '0;
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (cand[(int'(ptr) + i) % N_REQ]) idx = ID_W'((int'(ptr) + i) % N_REQ);
  end
endmodule

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: registered round-robin arbiter with bounded hold under contention
module rr_req_arbiter import arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int MAX_HOLD = 8,
  localparam int ID_W = clog2_min1(N_REQ),
  localparam int HOLD_W = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid
);
  state_t state, state_n;
  logic [ID_W-1:0] ptr, ptr_n, id_n, owner_nxt, pick_id;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [N_REQ-1:0] gnt_n, cand, pick_oh;
  logic pick_any, own, hold_max;
  // gnt is zero in IDLE, so cand collapses to req there and on release
  assign cand = req & ~gnt;
  assign own = |(req & gnt);
  assign hold_max = hold == HOLD_W'(MAX_HOLD);
  assign owner_nxt = gnt_id == ID_W'(N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .cand(cand),
    .ptr(state == GRANT ? owner_nxt : ptr),
    .oh(pick_oh),
    .idx(pick_id),
    .any(pick_any)
  );
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    id_n = gnt_id;
    ptr_n = ptr;
    hold_n = hold;
    if (state == IDLE) begin
      if (pick_any) begin
        state_n = GRANT;
        gnt_n = pick_oh;
        id_n = pick_id;
        hold_n = HOLD_W'(1);
      end
    end else if (!own || (pick_any && hold_max)) begin
      state_n = pick_any ? GRANT : IDLE;
      gnt_n = pick_oh;
      id_n = pick_id;
      ptr_n = owner_nxt;
      hold_n = pick_any ? HOLD_W'(1) : '0;
    end else begin
      hold_n = hold_max ? hold : hold + HOLD_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      ptr <= '0;
      hold <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      gnt_id <= id_n;
      gnt_valid <= |gnt_n;
      ptr <= ptr_n;
      hold <= hold_n;
    end
  end
endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb_rr_req_arbiter: vector table, directed corner sequences and model-checked random traffic
module tb_rr_req_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic gnt_valid;
  int checks = 0;
  int failures = 0;

  typedef struct packed {logic [3:0] gnt; logic [1:0] id; logic valid;} exp_t;
  typedef struct packed {logic [3:0] req; exp_t e;} vec_t;
  exp_t q[$];

  int m_owner, m_ptr, m_hold;

  rr_req_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
    else begin failures++; $display("FAIL onehot0 gnt=%b", gnt); end
  assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == |gnt)
    else begin failures++; $display("FAIL valid_or gnt_valid=%b gnt=%b", gnt_valid, gnt); end
  assert property (@(posedge clk) disable iff (!rst_n) (!gnt_valid && req != 0) |=> gnt_valid)
    else begin failures++; $display("FAIL idle_latency gnt_valid=%b required 1", gnt_valid); end
  for (genvar g = 0; g < 4; g++) begin : g_rose
    assert property (@(posedge clk) disable iff (!rst_n) $rose(gnt[g]) |-> $past(req[g]))
      else begin failures++; $display("FAIL rose_gnt%0d without prior req", g); end
  end

  function automatic exp_t mk(input logic [3:0] g);
    exp_t e;
    e.gnt = g;
    e.valid = |g;
    e.id = g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
    return e;
  endfunction

  function automatic int first_from(input logic [3:0] c, input int p);
    for (int i = 0; i < 4; i++) if (c[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic model(input logic [3:0] r, output exp_t e);
    logic [3:0] others;
    int nx;
    if (m_owner < 0) begin
      m_owner = first_from(r, m_ptr);
      if (m_owner >= 0) m_hold = 1;
    end else begin
      others = r & ~(4'b1 << m_owner);
      nx = (m_owner + 1) % 4;
      if (!r[m_owner]) begin
        m_ptr = nx;
        m_owner = first_from(r, nx);
        m_hold = (m_owner >= 0) ? 1 : 0;
      end else if (others == 0 || m_hold < 8) begin
        m_hold = (m_hold < 8) ? m_hold + 1 : 8;
      end else begin
        m_ptr = nx;
        m_owner = first_from(others, nx);
        m_hold = 1;
      end
    end
    e = mk(m_owner < 0 ? 4'b0 : 4'b1 << m_owner);
  endtask

  task automatic check(input string name);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = q.pop_front();
      if (gnt !== e.gnt || gnt_valid !== e.valid || (e.valid && gnt_id !== e.id)) begin
        failures++;
        $display("FAIL %s got gnt=%b id=%0d valid=%b required gnt=%b id=%0d valid=%b",
                 name, gnt, gnt_id, gnt_valid, e.gnt, e.id, e.valid);
      end
    end
  endtask

  task automatic drive(input logic [3:0] r, input exp_t e, input string name);
    @(negedge clk);
    req = r;
    q.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  vec_t tbl[13];
  exp_t e;
  logic [3:0] r;

  initial begin
    tbl[0]  = '{4'b0001, mk(4'b0001)};
    tbl[1]  = '{4'b0000, mk(4'b0000)};
    tbl[2]  = '{4'b1010, mk(4'b0010)};
    tbl[3]  = '{4'b1000, mk(4'b1000)};
    tbl[4]  = '{4'b1000, mk(4'b1000)};
    tbl[5]  = '{4'b0000, mk(4'b0000)};
    tbl[6]  = '{4'b0000, mk(4'b0000)};
    tbl[7]  = '{4'b0110, mk(4'b0010)};
    tbl[8]  = '{4'b0101, mk(4'b0100)};
    tbl[9]  = '{4'b0001, mk(4'b0001)};
    tbl[10] = '{4'b1001, mk(4'b0001)};
    tbl[11] = '{4'b1000, mk(4'b1000)};
    tbl[12] = '{4'b0000, mk(4'b0000)};
    repeat (3) @(posedge clk);
    #1;
    q.push_back(mk(4'b0));
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) drive(tbl[i].req, tbl[i].e, $sformatf("vec%0d", i));
    for (int c = 0; c < 32; c++)
      drive(4'b0101, mk(((c / 8) % 2) ? 4'b0100 : 4'b0001), $sformatf("rotate_c%0d", c));
    drive(4'b0000, mk(4'b0000), "rotate_release");
    for (int c = 0; c < 20; c++) drive(4'b1000, mk(4'b1000), $sformatf("sole_c%0d", c));
    drive(4'b1001, mk(4'b0001), "sole_saturated_rotate");
    drive(4'b0000, mk(4'b0000), "sole_release");
    drive(4'b0100, mk(4'b0100), "pre_reset_grant");
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    q.push_back(mk(4'b0));
    check("async_reset_mid_grant");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_owner = -1;
    m_ptr = 0;
    m_hold = 0;
    model(4'b1111, e);
    drive(4'b1111, mk(4'b0001), "post_reset_ptr0");
    r = 4'b1111;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      model(r, e);
      drive(r, e, $sformatf("rand_c%0d", c));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
